// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the seven-segment scan path.
// Results are double-buffered: digit outputs change only on the cycle a conversion completes.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_WIDTH-1:0] bin,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           digit_1,
  output logic [3:0]           digit_2,
  output logic [3:0]           digit_3,
  output logic [3:0]           digit_4
);

  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_reg, state_next;
  logic [BIN_WIDTH-1:0] bin_reg, bin_next;
  logic [15:0]          scratch_reg, scratch_next, scratch_adj;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 ovf_pend_reg, ovf_pend_next;
  logic                 done_reg, done_next;
  logic                 ovf_reg, ovf_next;
  logic [15:0]          digits_reg, digits_next;

  // Per-nibble add-3 correction; no carry propagates between nibbles.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                    ? scratch_reg[gi*4 +: 4] + 4'd3
                                    : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      digits_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      scratch_reg  <= scratch_next;
      cnt_reg      <= cnt_next;
      ovf_pend_reg <= ovf_pend_next;
      done_reg     <= done_next;
      ovf_reg      <= ovf_next;
      digits_reg   <= digits_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    scratch_next  = scratch_reg;
    cnt_next      = cnt_reg;
    ovf_pend_next = ovf_pend_reg;
    done_next     = 1'b0;
    ovf_next      = ovf_reg;
    digits_next   = digits_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          bin_next      = bin;
          scratch_next  = '0;
          cnt_next      = CW'(BIN_WIDTH);
          ovf_pend_next = (16'(bin) > 16'd9999);
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, bin_next} = {scratch_adj, bin_reg} << 1;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) state_next = DONE;
      end
      DONE: begin
        done_next = 1'b1;
        // Out-of-range values saturate the display at 9999.
        if (ovf_pend_reg) begin
          digits_next = 16'h9999;
          ovf_next    = 1'b1;
        end else begin
          digits_next = scratch_reg;
          ovf_next    = 1'b0;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign overflow = ovf_reg;
  assign digit_1  = digits_reg[3:0];
  assign digit_2  = digits_reg[7:4];
  assign digit_3  = digits_reg[11:8];
  assign digit_4  = digits_reg[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq with BIN_WIDTH=14.
// Each comparison is an immediate assertion; one summary line at the end.
module tb_bin_to_bcd_seq;

  localparam int BW = 14;

  logic          clk;
  logic          rst;
  logic [BW-1:0] bin;
  logic          start;
  logic          busy, done, overflow;
  logic [3:0]    digit_1, digit_2, digit_3, digit_4;

  int            passed = 0;
  int            total  = 0;
  int            cyc    = 0;
  logic [15:0]   prev_digits = 16'h0000;

  bin_to_bcd_seq #(.BIN_WIDTH(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin      (bin),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digit_1  (digit_1),
    .digit_2  (digit_2),
    .digit_3  (digit_3),
    .digit_4  (digit_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cur_digits();
    return {digit_4, digit_3, digit_2, digit_1};
  endfunction

  // One conversion: checks acceptance, hold-during-shift, latency, digits, overflow, single-cycle done.
  task automatic run_conv(input logic [BW-1:0] v, input logic [15:0] exp_dig,
                          input logic exp_ovf, input string tag);
    int  n;
    bit  got;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
      else if (n == BW - 1) check({tag, "_hold"}, 32'(cur_digits()), 32'(prev_digits));
    end
    check({tag, "_latency"}, 32'(n), 32'(BW + 1));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_digits"}, 32'(cur_digits()), 32'(exp_dig));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    prev_digits = exp_dig;
  endtask

  initial begin : stim
    int          ndone;
    int          t[3];
    int          k;
    logic [15:0] ref_dig;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #3;
    check("reset_state", 32'({busy, done, overflow, cur_digits()}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset with no start: everything stays quiet.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({busy, done, overflow, cur_digits()}), 32'd0);
    end

    run_conv(14'd1234,  16'h1234, 1'b0, "b1234");
    run_conv(14'd0,     16'h0000, 1'b0, "b0");
    run_conv(14'd9,     16'h0009, 1'b0, "b9");
    run_conv(14'd10,    16'h0010, 1'b0, "b10");
    run_conv(14'd9999,  16'h9999, 1'b0, "b9999");
    run_conv(14'd10000, 16'h9999, 1'b1, "b10000");
    run_conv(14'd16383, 16'h9999, 1'b1, "b16383");
    run_conv(14'd42,    16'h0042, 1'b0, "b42");

    // Sampled sweep against a decimal reference model.
    for (int v = 0; v <= 9999; v += 37) begin
      ref_dig = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      run_conv(14'(v), ref_dig, 1'b0, "sweep");
      check("sweep_range", 32'(digit_1 <= 9 && digit_2 <= 9 && digit_3 <= 9 && digit_4 <= 9), 32'd1);
    end

    // Start re-pulsed mid-conversion with a different bin: ignored.
    @(negedge clk);
    bin   = 14'd500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin   = 14'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        check("repulse_digits", 32'(cur_digits()), 32'h0500);
      end
    end
    check("repulse_one_done", 32'(ndone), 32'd1);
    prev_digits = 16'h0500;

    // Start held high: back-to-back conversions every BW+2 cycles.
    t[0] = -1000; t[1] = -2000; t[2] = -3000;
    k = 0;
    @(negedge clk);
    bin   = 14'd55;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done && k < 3) begin
        t[k] = cyc;
        k++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("hold_gap1", 32'(t[1] - t[0]), 32'(BW + 2));
    check("hold_gap2", 32'(t[2] - t[1]), 32'(BW + 2));
    repeat (20) @(negedge clk);
    check("hold_digits", 32'(cur_digits()), 32'h0055);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 32'({busy, done, overflow, cur_digits()}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    prev_digits = 16'h0000;
    run_conv(14'd77, 16'h0077, 1'b0, "b77");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
